// File: rtl/mem_cntl_pkg.sv
// Shared types and defaults for the memory-controller load/store responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_cntl_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP_STALL
    } state_e;

    // Request as carried on the load/store interface at the default widths.
    typedef struct packed {
        op_e                       cntl;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } req_t;

endpackage

// File: rtl/mem_cntl_sram.sv
// Single-port local PE SRAM, 2**ADDR_WIDTH words, synchronous write.
// Latency: read data registered, valid the cycle after en && !we.
// Backpressure: none; one access per cycle, rdata holds when not reading.
// Ports: clk; en/we select the access; addr/wdata request; rdata read result.
module mem_cntl_sram
    import mem_cntl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Read register holds its value between reads so a stalled consumer
    // upstream can still pick the data up later.
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem_q[addr];
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_cntl_ls_responder.sv
// Load/store responder: in-order request FIFO feeding the local SRAM, one load response register.
// Latency: LOAD accepted at edge T (idle path) shows mc__ls__valid after edge T+2; 1 req/cycle sustained.
// Backpressure: mc__ls__ready = registered FIFO-not-full; held load response stalls later LOADs, STOREs drain.
// Ports: ls__mc__* request in (valid/ready), mc__ls__* load response out (valid/ready),
//        mc__ls__outstanding = accepted loads not yet consumed.
module mem_cntl_ls_responder
    import mem_cntl_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REQ_FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset_poweron,
    input  logic                                ls__mc__valid,
    input  logic                                ls__mc__cntl,
    input  logic [ADDR_WIDTH-1:0]               ls__mc__addr,
    input  logic [DATA_WIDTH-1:0]               ls__mc__data,
    output logic                                mc__ls__ready,
    output logic                                mc__ls__valid,
    output logic [DATA_WIDTH-1:0]               mc__ls__data,
    input  logic                                ls__mc__ready,
    output logic [$clog2(REQ_FIFO_DEPTH)+1:0]   mc__ls__outstanding
);

    localparam int PTR_W = $clog2(REQ_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = PTR_W + 2;

    // Parameter-sized form of mem_cntl_pkg::req_t.
    typedef struct packed {
        op_e                   cntl;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } ent_t;

    ent_t                  fifo_q [REQ_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ready_q, ready_d;
    state_e                state_q, state_d;
    op_e                   cur_op_q, cur_op_d;
    logic                  resp_vld_q, resp_vld_d;
    logic [DATA_WIDTH-1:0] resp_dat_q, resp_dat_d;
    logic [OUT_W-1:0]      outst_q, outst_d;

    logic                  push, pop, fifo_nempty;
    logic                  resp_cons, resp_free, load_acc;
    logic                  sram_en;
    logic [DATA_WIDTH-1:0] sram_rdata;
    ent_t                  head, wr_ent;

    assign push        = ls__mc__valid && ready_q;
    assign fifo_nempty = (count_q != '0);
    assign head        = fifo_q[rd_ptr_q];
    assign wr_ent      = '{cntl: op_e'(ls__mc__cntl), addr: ls__mc__addr, data: ls__mc__data};
    assign resp_cons   = resp_vld_q && ls__mc__ready;
    // The response register can take new data this cycle.
    assign resp_free   = !resp_vld_q || resp_cons;
    assign load_acc    = push && (op_e'(ls__mc__cntl) == OP_LOAD);
    // A pop on a reset edge must not touch the SRAM: queued requests are discarded.
    assign sram_en     = pop && !reset_poweron;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        resp_vld_d = resp_vld_q && !resp_cons;
        resp_dat_d = resp_dat_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // A LOAD whose response slot is still occupied waits here; the
                // SRAM read register holds its data because no new access is issued.
                if (cur_op_q == OP_STORE || resp_free) begin
                    if (cur_op_q == OP_LOAD) begin
                        resp_vld_d = 1'b1;
                        resp_dat_d = sram_rdata;
                    end
                    if (!fifo_nempty) begin
                        state_d = ST_IDLE;
                    end else if (head.cntl == OP_STORE || resp_free) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_RESP_STALL;
                    end
                end
            end
            ST_RESP_STALL: begin
                if (resp_free) begin
                    if (fifo_nempty) begin
                        pop     = 1'b1;
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cur_op_d = pop ? head.cntl : cur_op_q;
        wr_ptr_d = push ? PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop  ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CNT_W'(REQ_FIFO_DEPTH));
        // Bounded by FIFO depth + ACCESS + response register, so it cannot wrap.
        case ({load_acc, resp_cons})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   outst_d = outst_q - OUT_W'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= wr_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            state_q    <= ST_IDLE;
            cur_op_q   <= OP_LOAD;
            resp_vld_q <= 1'b0;
            resp_dat_q <= '0;
            outst_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            state_q    <= state_d;
            cur_op_q   <= cur_op_d;
            resp_vld_q <= resp_vld_d;
            resp_dat_q <= resp_dat_d;
            outst_q    <= outst_d;
        end
    end

    mem_cntl_sram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (head.cntl == OP_STORE),
        .addr  (head.addr),
        .wdata (head.data),
        .rdata (sram_rdata)
    );

    assign mc__ls__ready       = ready_q;
    assign mc__ls__valid       = resp_vld_q;
    assign mc__ls__data        = resp_dat_q;
    assign mc__ls__outstanding = outst_q;

endmodule

// File: tb/tb_mem_cntl_ls_responder.sv
// Self-checking bench for mem_cntl_ls_responder with a reference memory and response scoreboard.
// Latency: n/a.
// Backpressure: drives random and fixed ready patterns on both interfaces.
module tb_mem_cntl_ls_responder;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int OUT_W = $clog2(DEPTH) + 2;

    logic             clk = 1'b0;
    logic             reset_poweron;
    logic             ls__mc__valid;
    logic             ls__mc__cntl;
    logic [AW-1:0]    ls__mc__addr;
    logic [DW-1:0]    ls__mc__data;
    logic             mc__ls__ready;
    logic             mc__ls__valid;
    logic [DW-1:0]    mc__ls__data;
    logic             ls__mc__ready;
    logic [OUT_W-1:0] mc__ls__outstanding;

    always #5 clk = ~clk;

    mem_cntl_ls_responder #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .REQ_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                 (clk),
        .reset_poweron       (reset_poweron),
        .ls__mc__valid       (ls__mc__valid),
        .ls__mc__cntl        (ls__mc__cntl),
        .ls__mc__addr        (ls__mc__addr),
        .ls__mc__data        (ls__mc__data),
        .mc__ls__ready       (mc__ls__ready),
        .mc__ls__valid       (mc__ls__valid),
        .mc__ls__data        (mc__ls__data),
        .ls__mc__ready       (ls__mc__ready),
        .mc__ls__outstanding (mc__ls__outstanding)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [DW-1:0] ref_mem [2**AW];
    logic [DW-1:0] exp_q [$];
    int          model_out = 0;
    bit          mon_en = 0;

    // Scoreboard: accepted requests update the reference memory / expected queue,
    // consumed responses are popped and compared, outstanding checked every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (mc__ls__outstanding !== OUT_W'(model_out)) begin
                n_fail++;
                $display("FAIL outstanding: got %0d expected %0d at %0t", mc__ls__outstanding, model_out, $time);
            end
            if (reset_poweron) begin
                exp_q.delete();
                model_out = 0;
            end else begin
                if (mc__ls__valid && ls__mc__ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL resp_unexpected: got data %h with nothing expected at %0t", mc__ls__data, $time);
                    end else begin
                        logic [DW-1:0] e;
                        e = exp_q.pop_front();
                        if (mc__ls__data !== e) begin
                            n_fail++;
                            $display("FAIL resp_data: got %h expected %h at %0t", mc__ls__data, e, $time);
                        end
                    end
                    model_out--;
                end
                if (ls__mc__valid && mc__ls__ready) begin
                    if (ls__mc__cntl) begin
                        ref_mem[ls__mc__addr] = ls__mc__data;
                    end else begin
                        exp_q.push_back(ref_mem[ls__mc__addr]);
                        model_out++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ls__mc__valid = 1'b0;
    endtask

    // Present one request and return just after the edge that accepted it.
    task automatic send(input logic c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc;
        int t = 0;
        ls__mc__valid = 1'b1;
        ls__mc__cntl  = c;
        ls__mc__addr  = a;
        ls__mc__data  = d;
        do begin
            @(negedge clk);
            acc = mc__ls__ready;
            tick();
            t++;
        end while (!acc && t < 500);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept, required accept within 500 cycles");
        end
    endtask

    task automatic drain();
        int t = 0;
        ls__mc__ready = 1'b1;
        while ((exp_q.size() != 0 || mc__ls__outstanding != '0) && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
        end
        repeat (2) tick();
    endtask

    task automatic wait_resp(input string name, input logic [DW-1:0] expv);
        bit found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (mc__ls__valid) begin
                found = 1;
                n_checks++;
                if (mc__ls__data !== expv) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h", name, mc__ls__data, expv);
                end
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no response, required %h", name, expv);
        end
        tick();
    endtask

    task automatic test_reset();
        reset_poweron = 1'b1;
        ls__mc__valid = 1'b0;
        ls__mc__cntl  = 1'b0;
        ls__mc__addr  = '0;
        ls__mc__data  = '0;
        ls__mc__ready = 1'b0;
        repeat (3) tick();
        n_checks += 4;
        if (mc__ls__ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", mc__ls__ready); end
        if (mc__ls__valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", mc__ls__valid); end
        if (mc__ls__data !== '0) begin n_fail++; $display("FAIL reset_data: got %h required 0", mc__ls__data); end
        if (mc__ls__outstanding !== '0) begin n_fail++; $display("FAIL reset_outstanding: got %0d required 0", mc__ls__outstanding); end
        reset_poweron = 1'b0;
        tick();
        n_checks += 2;
        if (mc__ls__ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b required 1", mc__ls__ready); end
        if (mc__ls__valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b required 0", mc__ls__valid); end
    endtask

    task automatic init_mem();
        ls__mc__ready = 1'b1;
        for (int a = 0; a < 2**AW; a++) begin
            send(1'b1, AW'(a), $urandom);
        end
        idle();
        drain();
    endtask

    task automatic test_single();
        ls__mc__ready = 1'b1;
        send(1'b1, 10'h005, 32'hDEADBEEF);
        send(1'b0, 10'h005, '0);
        idle();
        tick();
        n_checks++;
        if (mc__ls__valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got valid %b one cycle after accept, required 0", mc__ls__valid); end
        tick();
        n_checks += 2;
        if (mc__ls__valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: got valid %b two cycles after accept, required 1", mc__ls__valid); end
        if (mc__ls__data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h required deadbeef", mc__ls__data); end
        repeat (3) tick();
        n_checks++;
        if (mc__ls__valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_count: got valid %b pending %0d, required 0 and 0", mc__ls__valid, exp_q.size());
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [23:0] vbits = '0;
        int first = -1;
        int total = 0;
        int run = 0;
        ls__mc__ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) send(1'b0, AW'(100 + i), '0);
                idle();
            end
            begin
                for (int c = 0; c < 24; c++) begin
                    @(negedge clk);
                    vbits[c] = mc__ls__valid;
                end
            end
        join
        for (int c = 0; c < 24; c++) begin
            if (vbits[c]) begin
                total++;
                if (first < 0) first = c;
            end
        end
        for (int c = 0; c < 24; c++) begin
            if (first >= 0 && c >= first && c < first + 8 && vbits[c]) run++;
        end
        n_checks += 2;
        if (total != 8) begin n_fail++; $display("FAIL b2b_count: got %0d responses required 8", total); end
        if (run != 8) begin n_fail++; $display("FAIL b2b_consecutive: got %0d consecutive required 8", run); end
        drain();
    endtask

    task automatic test_backpressure();
        bit          acc;
        bit          seen = 0;
        int          n_acc = 0;
        int          unstable = 0;
        int          maxo = 0;
        logic [DW-1:0] d0 = '0;
        logic [AW-1:0] a = 10'd200;
        ls__mc__ready = 1'b0;
        ls__mc__valid = 1'b1;
        ls__mc__cntl  = 1'b0;
        ls__mc__addr  = a;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            acc = mc__ls__ready;
            if (int'(mc__ls__outstanding) > maxo) maxo = int'(mc__ls__outstanding);
            if (mc__ls__valid) begin
                if (!seen) begin
                    seen = 1;
                    d0 = mc__ls__data;
                end else if (mc__ls__data !== d0) begin
                    unstable++;
                end
            end else if (seen) begin
                unstable++;
            end
            tick();
            if (acc) begin
                n_acc++;
                a = a + 1'b1;
                ls__mc__addr = a;
            end
        end
        idle();
        @(negedge clk);
        n_checks += 4;
        if (n_acc != 6) begin n_fail++; $display("FAIL bp_accepts: got %0d accepted required 6", n_acc); end
        if (mc__ls__ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b required 0", mc__ls__ready); end
        if (maxo != 6 || mc__ls__outstanding !== OUT_W'(6)) begin
            n_fail++;
            $display("FAIL bp_outstanding: got max %0d now %0d required 6", maxo, mc__ls__outstanding);
        end
        if (!seen || unstable != 0) begin
            n_fail++;
            $display("FAIL bp_stable: got seen %0d changes %0d required 1 and 0", seen, unstable);
        end
        tick();
        drain();
    endtask

    task automatic test_raw();
        ls__mc__ready = 1'b1;
        send(1'b1, 10'h3FF, 32'h12345678);
        send(1'b0, 10'h3FF, '0);
        idle();
        wait_resp("raw_data", 32'h12345678);
        drain();
    endtask

    task automatic test_mid_reset();
        ls__mc__ready = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b0, AW'(300 + i), '0);
        idle();
        tick();
        n_checks++;
        if (mc__ls__valid !== 1'b1) begin n_fail++; $display("FAIL mr_held: got valid %b required 1", mc__ls__valid); end
        reset_poweron = 1'b1;
        tick();
        reset_poweron = 1'b0;
        n_checks += 3;
        if (mc__ls__valid !== 1'b0) begin n_fail++; $display("FAIL mr_valid: got %b required 0", mc__ls__valid); end
        if (mc__ls__outstanding !== '0) begin n_fail++; $display("FAIL mr_outstanding: got %0d required 0", mc__ls__outstanding); end
        if (mc__ls__ready !== 1'b0) begin n_fail++; $display("FAIL mr_ready_low: got %b required 0", mc__ls__ready); end
        tick();
        n_checks++;
        if (mc__ls__ready !== 1'b1) begin n_fail++; $display("FAIL mr_ready_high: got %b required 1", mc__ls__ready); end
        ls__mc__ready = 1'b1;
        begin
            int nv = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (mc__ls__valid) nv++;
                tick();
            end
            n_checks++;
            if (nv != 0) begin n_fail++; $display("FAIL mr_fifo_empty: got %0d responses required 0", nv); end
        end
        send(1'b0, 10'h005, '0);
        idle();
        wait_resp("mr_keep_005", 32'hDEADBEEF);
        send(1'b0, 10'h3FF, '0);
        idle();
        wait_resp("mr_keep_3ff", 32'h12345678);
        drain();
    endtask

    task automatic test_random();
        bit done = 0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        tick();
                    end
                    send(1'($urandom_range(0, 1)), AW'($urandom), $urandom);
                end
                idle();
                done = 1;
            end
            begin
                while (!done) begin
                    ls__mc__ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        mon_en = 1;
        init_mem();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_raw();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_cntl_ls_responder.md
MEM_CNTL_LS_RESPONDER -- requirements
Module: mem_cntl_ls_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word address width into the local PE SRAM.
REQ-002 Parameter DATA_WIDTH, default 32, data width of one SRAM word.
REQ-003 Parameter REQ_FIFO_DEPTH, default 4, number of request FIFO entries; SHALL be a power of 2 and at least 2.
REQ-004 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-005 reset_poweron  input  1  reset; SHALL be synchronous and active-high.
REQ-006 ls__mc__valid  input  1  load/store request valid.
REQ-007 ls__mc__cntl  input  1  request opcode: 0 = LOAD, 1 = STORE.
REQ-008 ls__mc__addr  input  ADDR_WIDTH  request word address.
REQ-009 ls__mc__data  input  DATA_WIDTH  store data; ignored for LOAD.
REQ-010 mc__ls__ready  output  1  request accepted when this and ls__mc__valid are both high on a clock edge.
REQ-011 mc__ls__valid  output  1  load response valid.
REQ-012 mc__ls__data  output  DATA_WIDTH  load response data.
REQ-013 ls__mc__ready  input  1  response consumed when this and mc__ls__valid are both high on a clock edge.
REQ-014 mc__ls__outstanding  output  $clog2(REQ_FIFO_DEPTH)+2  number of accepted loads whose response has not yet been consumed.

Function
REQ-015 mc__ls__ready SHALL equal "request FIFO not full", registered; a request SHALL NOT be dropped or duplicated.
REQ-016 The request FIFO SHALL be in-order, with registered read/write pointers and a count.
- FIFO full and a same-cycle pop SHALL still show ready low for that cycle.
- Simultaneous push and pop SHALL leave the count unchanged.
REQ-017 The access FSM SHALL have three states: IDLE, ACCESS, RESP_STALL.
- IDLE: if the FIFO is non-empty, pop the head and issue it to the SRAM, then go to ACCESS; otherwise stay in IDLE.
- ACCESS: a STORE completes here with no response.
- ACCESS, LOAD: SRAM data is captured into the response register and mc__ls__valid is asserted.
- From ACCESS, if another entry is waiting and the response register is free or being consumed this cycle, pop the next entry back-to-back; otherwise go to IDLE or RESP_STALL.
- RESP_STALL: entered while a LOAD response is held and the next entry is a LOAD; stay until the response is consumed.
REQ-018 Load latency SHALL be 2 cycles: a LOAD accepted at edge T, with the FIFO empty and the response path free, SHALL show mc__ls__valid high after edge T+2.
REQ-019 Throughput SHALL be one request per cycle while responses are consumed every cycle.
REQ-020 mc__ls__valid and mc__ls__data SHALL stay stable until consumed.
REQ-021 STOREs SHALL continue to drain while a LOAD response is stalled, until a LOAD reaches the FIFO head.
REQ-022 Ordering: a LOAD SHALL return the data of the most recent earlier-accepted STORE to the same address, including a STORE accepted in the immediately preceding cycle.
REQ-023 mc__ls__outstanding SHALL increment on LOAD accept and decrement on response consume.
- Both in the same cycle SHALL leave it unchanged.
- It SHALL never wrap.
REQ-024 Address arithmetic SHALL be unsigned; every ADDR_WIDTH address is valid and there is no out-of-range path.

Reset
REQ-025 When reset_poweron is high at a clock edge, the following SHALL apply on the next cycle:
- mc__ls__ready = 0 during reset, and 1 from the first cycle after reset deasserts.
- mc__ls__valid = 0, mc__ls__data = 0, mc__ls__outstanding = 0.
- FIFO empty; FSM in IDLE.
REQ-026 A reset asserted mid-operation SHALL discard queued requests and any held response; SRAM contents SHALL NOT be cleared.

Structure
REQ-027 Shared package mem_cntl_pkg SHALL hold:
- the opcode enum (LOAD, STORE);
- the FSM state enum;
- the default ADDR_WIDTH and DATA_WIDTH constants;
- the request struct {cntl, addr, data}.
REQ-028 One sub-module, mem_cntl_sram: single-port, synchronous write, 1-cycle registered read, 2**ADDR_WIDTH words.
REQ-029 The request FIFO SHALL be written inline, not as a separate module.

Verification
REQ-030 Single access: STORE addr 0x005 data 0xDEADBEEF, then LOAD 0x005 -> one response, data 0xDEADBEEF, exactly 2 cycles after the LOAD accept.
REQ-031 Back-to-back loads: 8 LOADs on consecutive cycles with ls__mc__ready held high -> 8 responses on consecutive cycles, in order, data matching a reference model.
REQ-032 Backpressure: ls__mc__ready held low for 10 cycles -> the following SHALL hold:
- mc__ls__ready drops after 4 queued requests;
- mc__ls__data stays stable;
- mc__ls__outstanding reaches at most 6;
- no loss and no reorder after release.
REQ-033 RAW hazard: STORE 0x3FF data 0x12345678 immediately followed by LOAD 0x3FF -> response 0x12345678.
REQ-034 Mid-operation reset: reset_poweron pulsed for 1 cycle with 3 requests queued and a response held -> on the next cycle valid = 0, outstanding = 0, FIFO empty; earlier-completed stores remain readable.
REQ-035 Random: 10k random requests with random ready on both sides -> scoreboard match, and mc__ls__outstanding always equals the model's count.
